// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table extractor and its settle counter.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int DEFAULT_N_IN          = 3;
    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int SETTLE_W              = $clog2(DEFAULT_SETTLE_CYCLES + 1);

    // Number of input combinations swept for an N-input circuit.
    function automatic int n_comb(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int settle_w(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-interval counter: synchronous clear, count enable, terminal-count flag.
module tt_settle_counter
    import tt_pkg::*;
#(
    parameter int W        = SETTLE_W,
    parameter int TERMINAL = DEFAULT_SETTLE_CYCLES - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] TC = W'(TERMINAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps a combinational CUT through every input combination and assembles its truth-table code.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected_code,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_code,
    output logic                 match
);

    localparam int NCOMB = n_comb(N_IN);
    localparam int CNT_W = settle_w(SETTLE_CYCLES);

    tt_state_e        state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [NCOMB-1:0] code_q, code_d;
    logic [NCOMB-1:0] exp_q, exp_d;
    logic             match_q, match_d;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_tc;

    tt_settle_counter #(
        .W        (CNT_W),
        .TERMINAL (SETTLE_CYCLES - 1)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        exp_d    = exp_q;
        match_d  = match_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d    = expected_code;
                    code_d   = '0;
                    match_d  = 1'b0;
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Bit position 2**N_IN-1-idx is simply the bitwise inverse of idx.
                code_d[~idx_q] = dut_out;
                if (&idx_q) begin
                    match_d = (code_d == exp_q);
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            exp_q   <= exp_d;
            match_q <= match_d;
        end
    end

    // idx only advances on the SAMPLE->SETTLE edge, so dut_in is stable across each sample.
    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign dut_in     = busy ? idx_q : '0;
    assign done       = (state_q == DONE);
    assign table_code = code_q;
    assign match      = match_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Randomized scoreboard bench for truth_table_extractor: reference model built from the code convention.
module tb_truth_table_extractor;

    localparam int NI  = 3;
    localparam int NC  = 8;
    localparam int S   = 4;
    localparam int LAT = NC * (S + 1) + 1;
    localparam int S1   = 1;
    localparam int LAT1 = NC * (S1 + 1) + 1;

    typedef struct {
        logic [7:0] code;
        logic       m;
        int         done_cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    expected_code;
    logic          dut_out;
    logic [NI-1:0] dut_in;
    logic          busy;
    logic          done;
    logic [7:0]    table_code;
    logic          match;

    logic          start1;
    logic [7:0]    expected_code1;
    logic          dut_out1;
    logic [NI-1:0] dut_in1;
    logic          busy1;
    logic          done1;
    logic [7:0]    table_code1;
    logic          match1;
    logic [7:0]    code1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_count = 0;
    int   t_drive = -1000;
    int   cut_kind = 0;
    logic [7:0] cut_code = 8'h00;
    exp_t sb_q[$];

    truth_table_extractor #(.N_IN(NI), .SETTLE_CYCLES(S)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .expected_code (expected_code),
        .dut_out       (dut_out),
        .dut_in        (dut_in),
        .busy          (busy),
        .done          (done),
        .table_code    (table_code),
        .match         (match)
    );

    truth_table_extractor #(.N_IN(NI), .SETTLE_CYCLES(S1)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .start         (start1),
        .expected_code (expected_code1),
        .dut_out       (dut_out1),
        .dut_in        (dut_in1),
        .busy          (busy1),
        .done          (done1),
        .table_code    (table_code1),
        .match         (match1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // CUT kinds: 0 table, 1 const-0, 2 const-1, 3 out=in3, 4 out=in1, 5 table with noise outside SAMPLE.
    function automatic logic cut_fn(input int kind, input logic [7:0] code, input logic [2:0] idx);
        case (kind)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return idx[0];
            4:       return idx[2];
            default: return code[7 - int'(idx)];
        endcase
    endfunction

    function automatic logic [7:0] ref_code(input int kind, input logic [7:0] code);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            r[NC - 1 - i] = cut_fn(kind, code, 3'(i));
        end
        return r;
    endfunction

    // CUT model: noise kind is random on every non-sample cycle of the sweep timeline.
    always @(negedge clk) begin
        int k;
        k = cyc - t_drive - 1;
        if (cut_kind == 5 && k >= 0 && k < NC * (S + 1) && (k % (S + 1)) != S) begin
            dut_out = 1'($urandom_range(0, 1));
        end else begin
            dut_out = cut_fn(cut_kind, cut_code, dut_in);
        end
    end

    always_comb dut_out1 = code1[3'd7 - dut_in1];

    // Monitor: pops the scoreboard whenever the DUT presents done.
    always @(negedge clk) begin
        exp_t e;
        logic done_prev;
        if (done) begin
            done_count++;
            if (done_prev) check("done_one_cycle", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("table_code", 32'(table_code), 32'(e.code));
                check("match", 32'(match), 32'(e.m));
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
            end
        end
        done_prev = done;
    end

    task automatic run_sweep(input int kind, input logic [7:0] fcode, input logic [7:0] exp_c,
                             input bit extra_starts, input bit check_steps);
        exp_t e;
        int   step_err;
        logic [7:0] r;
        step_err = 0;
        cut_kind = kind;
        cut_code = fcode;
        r = ref_code(kind, fcode);
        @(negedge clk);
        expected_code = exp_c;
        start = 1'b1;
        t_drive = cyc;
        e.code = r;
        e.m = (r == exp_c);
        e.done_cyc = cyc + LAT;
        sb_q.push_back(e);
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            start = extra_starts && (k == 3 || k == 10 || k == LAT - 1);
            expected_code = 8'($urandom);
            if (k < NC * (S + 1)) begin
                if (dut_in !== 3'(k / (S + 1)) || busy !== 1'b1) step_err++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        check("code_hold", 32'(table_code), 32'(r));
        check("match_hold", 32'(match), 32'(r == exp_c));
        check("idle_after", 32'({busy, dut_in}), 32'd0);
        if (check_steps) check("dut_in_steps", 32'(step_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        int base;
        exp_t e;
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        expected_code = 8'h00;
        expected_code1 = 8'h00;
        code1 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_dut_in", 32'(dut_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_table_code", 32'(table_code), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_dut1", 32'({busy1, done1, match1, table_code1, dut_in1}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(0, 8'h47, 8'h47, 1'b0, 1'b1);
        run_sweep(1, 8'h00, 8'h47, 1'b0, 1'b0);
        run_sweep(2, 8'h00, 8'h47, 1'b0, 1'b0);
        run_sweep(3, 8'h00, 8'h55, 1'b0, 1'b1);
        run_sweep(4, 8'h00, 8'h0F, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            c = 8'($urandom);
            run_sweep(0, c, ($urandom_range(0, 1) != 0) ? c : 8'($urandom), 1'b0, 1'b0);
        end

        // Reset mid-sweep: outputs clear asynchronously and no done follows.
        cut_kind = 0;
        cut_code = 8'h47;
        @(negedge clk);
        expected_code = 8'h47;
        start = 1'b1;
        t_drive = cyc;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        base = done_count;
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dut_in", 32'(dut_in), 32'd0);
        check("abort_code", 32'(table_code), 32'd0);
        check("abort_done_match", 32'({done, match}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'(base));
        run_sweep(0, 8'hA3, 8'hA3, 1'b0, 1'b1);

        // Stray starts while busy and in DONE are ignored.
        run_sweep(0, 8'h3C, 8'h3D, 1'b1, 1'b1);

        // start held high: second sweep accepted on the IDLE cycle after DONE.
        c = 8'($urandom);
        cut_kind = 0;
        cut_code = c;
        @(negedge clk);
        expected_code = c;
        start = 1'b1;
        e.code = c;
        e.m = 1'b1;
        e.done_cyc = cyc + LAT;
        sb_q.push_back(e);
        e.done_cyc = cyc + 2 * LAT + 1;
        sb_q.push_back(e);
        for (int k = 0; k <= 2 * LAT + 8; k++) begin
            @(negedge clk);
            if (k == LAT + 4) start = 1'b0;
        end
        check("b2b_both_done", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Noise on dut_out outside SAMPLE must not reach the code.
        run_sweep(5, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_sweep(5, 8'h96, 8'h96, 1'b0, 1'b0);

        // SETTLE_CYCLES = 1 instance.
        code1 = 8'($urandom);
        @(negedge clk);
        expected_code1 = code1;
        start1 = 1'b1;
        base = cyc;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 3 * LAT1 && !done1; n++) @(negedge clk);
        check("s1_done", 32'(done1), 32'd1);
        check("s1_latency", 32'(cyc - base), 32'(LAT1));
        check("s1_code", 32'(table_code1), 32'(code1));
        check("s1_match", 32'(match1), 32'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential characterizer: the read side of the 3-input combinational truth-table gates in the tested-circuit set.
- Steps a circuit-under-test (CUT) through all 2^N_IN input combinations, waits a settle interval, and samples the CUT output for each one.
- Assembles the hex truth-table code (for example 8'h47) and compares it with an expected code.
- Used in self-check benches and FPGA harnesses that verify each tested circuit against its name.

Parameters:
- N_IN, 3: number of CUT inputs; legal range 1..4.
- SETTLE_CYCLES, 4: clock cycles dut_in is held before sampling; minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a sweep; honoured only in IDLE.
- expected_code  input  2**N_IN  reference code; sampled on the cycle start is accepted.
- dut_out  input  1  CUT output, synchronous to clk at the CUT boundary.
- dut_in  output  N_IN  CUT input drive; MSB = in1, LSB = in(N_IN).
- busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- done  output  1  one-cycle pulse when table_code and match are valid.
- table_code  output  2**N_IN  extracted truth-table code.
- match  output  1  table_code == latched expected_code; valid from done onward.

Behaviour:
Reset (asynchronous, active-high):
- State = IDLE; dut_in, busy, done, table_code, match, the index counter, the settle counter and the expected latch are all 0.
- Reset asserted mid-sweep aborts immediately. No done pulse is produced.

Code convention (fixed):
- Combination index idx = dut_in value.
- CUT output for idx goes to table_code bit (2**N_IN-1-idx), so input 000 maps to the MSB.
- Example: outputs 0,1,0,0,0,1,1,1 for idx 0..7 give 8'h47.

States:
- IDLE: dut_in = 0, busy = 0. start=1 -> latch expected_code, clear table_code and match, idx = 0, cnt = 0, go to SETTLE.
- SETTLE: dut_in = idx; cnt increments each cycle. When cnt == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: dut_in = idx; write dut_out into bit (2**N_IN-1-idx).
  - If idx == 2**N_IN-1, go to DONE.
  - Otherwise idx += 1, cnt = 0, go to SETTLE.
- DONE: done = 1 for exactly one cycle; match = (final table_code == latch); always go to IDLE.

Timing and boundaries:
- Each combination takes SETTLE_CYCLES+1 cycles.
- done is asserted 2**N_IN*(SETTLE_CYCLES+1)+1 cycles after the start edge (41 cycles at the defaults).
- table_code and match hold after DONE until the next accepted start.
- start while busy or in DONE is ignored (not queued).
- start held high continuously re-launches a sweep on the first IDLE cycle after DONE.
- dut_in changes only on SETTLE entry, never in SAMPLE, so there are no glitches at sample time.
- idx never wraps past 2**N_IN-1.
- dut_out is sampled only in SAMPLE; changes during SETTLE have no effect.

Decomposition:
- Package tt_pkg holds:
  - the state typedef enum {IDLE, SETTLE, SAMPLE, DONE};
  - function n_comb(N_IN) = 2**N_IN;
  - localparam SETTLE_W = $clog2(SETTLE_CYCLES+1).
- One natural sub-module, tt_settle_counter: load, count-enable, terminal-count flag.
- The FSM, index counter and code register stay in the top module.

Test Plan:
1. CUT model for 0x47 (out = 1 at idx 1,5,6,7), expected_code = 8'h47, start pulse -> done 41 cycles after start, table_code = 8'h47, match = 1.
2. Constant-0 CUT, expected_code = 8'h47 -> table_code = 8'h00, match = 0; constant-1 CUT -> table_code = 8'hFF.
3. CUT out = in3 -> table_code = 8'h55; CUT out = in1 -> 8'h0F. Check dut_in steps 0..7, each value held for 5 cycles.
4. rst asserted at cycle 17 of a sweep -> all outputs 0 asynchronously, state IDLE, no done. A fresh start then gives a correct full sweep.
5. start pulsed at cycles 3, 10 and DONE during a sweep -> ignored, single done, timing unchanged. Back-to-back sweeps with start held high -> second sweep begins the cycle after IDLE is re-entered.
6. CUT output toggled only during SETTLE (stable 1 at SAMPLE) -> all captured bits = 1. SETTLE_CYCLES = 1 variant -> done 17 cycles after start.
